native_wait_ram: RTL and testbench



---
 rtl/native_wait_ram.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_native_wait_ram.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_wait_ram.sv
// native_wait_ram: memory and IO slave for the picorv32 native memory port.
// It has a byte-addressable RAM, programmable wait states, a console byte port,
// a free-running cycle counter and a sticky error flag for unmapped accesses.
// Optional transaction statistics are built when NATIVE_RAM_STATS_EN is defined.
// Without that macro, the statistics offsets read as zero.
module native_wait_ram #(
   parameter int          MEM_WORDS   = 256,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] IO_ADDR     = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        io_valid,
   output logic [7:0]  io_data,
   output logic        err,
   output logic [31:0] err_addr
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
   localparam logic [29:0] IO_W      = IO_ADDR[31:2];
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rsel_ram_q, rsel_ram_d;
   logic        io_valid_q, io_valid_d;
   logic [7:0]  io_data_q, io_data_d;
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [31:0] cycle_q, cycle_d;

   // The request currently being served: live port signals in IDLE, latched copy afterwards.
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic [29:0] req_word;
   logic        req_is_ram;
   logic        req_unmapped;
   logic [4:0]  io_hit;
   logic [31:0] stat_rd;

   logic          access;
   logic          ram_en;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_rd;

   genvar gi;

   // Select the request source so zero-wait accesses decode the port directly.
   always_comb begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_wstrb = wstrb_q;
      if (state_q == S_IDLE) begin
         req_addr  = mem_addr;
         req_wdata = mem_wdata;
         req_wstrb = mem_wstrb;
      end
   end

   assign req_word   = req_addr[31:2];
   assign req_is_ram = (req_addr < RAM_BYTES);
   assign ram_idx    = req_addr[AW+1:2];

   // One hit line per IO register: console, cycle counter, fetch/read/write statistics.
   generate
      for (gi = 0; gi < 5; gi++) begin : g_io_hit
         assign io_hit[gi] = (req_word == IO_W + 30'(gi));
      end
   endgenerate

   assign req_unmapped = !req_is_ram && !(|io_hit);

   // Next-state, access decode and output register updates.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      ready_d    = 1'b0;
      rdata_d    = rdata_q;
      rsel_ram_d = rsel_ram_q;
      io_valid_d = 1'b0;
      io_data_d  = io_data_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      cycle_d    = cycle_q + 32'd1;
      access     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_valid) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!mem_valid) begin
               // The core withdrew its request: abandon it without touching memory.
               state_d = S_IDLE;
               err_d   = 1'b1;
               if (!err_q) begin
                  err_addr_d = addr_q;
               end
            end else if (cnt_q <= 4'd1) begin
               access  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // Turnaround cycle: mem_ready is high now, so nothing new is accepted.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (access) begin
         ready_d    = 1'b1;
         rsel_ram_d = req_is_ram;
         rdata_d    = 32'd0;
         if (io_hit[0] && (req_wstrb != 4'd0)) begin
            io_valid_d = 1'b1;
            io_data_d  = req_wdata[7:0];
         end
         if (io_hit[1]) begin
            rdata_d = cycle_q;
         end
         if (|io_hit[4:2]) begin
            rdata_d = stat_rd;
         end
         if (req_unmapped) begin
            err_d = 1'b1;
            if (!err_q) begin
               err_addr_d = req_addr;
            end
         end
      end
   end

   // Control and output registers; reset wins over any request on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         wstrb_q    <= 4'd0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'd0;
         rsel_ram_q <= 1'b0;
         io_valid_q <= 1'b0;
         io_data_q  <= 8'd0;
         err_q      <= 1'b0;
         err_addr_q <= 32'd0;
         cycle_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         rsel_ram_q <= rsel_ram_d;
         io_valid_q <= io_valid_d;
         io_data_q  <= io_data_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         cycle_q    <= cycle_d;
      end
   end

   // A reset on the access edge must not let a write land in RAM.
   assign ram_en = access && req_is_ram && !reset;

   // RAM built as four byte columns, so each write strobe maps to one column.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_WORDS];
         logic [7:0] lane_rd_q;

         // Read-before-write byte column with a registered read port.
         always_ff @(posedge clk) begin
            if (ram_en) begin
               lane_rd_q <= lane_mem[ram_idx];
               if (req_wstrb[gi]) begin
                  lane_mem[ram_idx] <= req_wdata[8*gi +: 8];
               end
            end
         end

         assign ram_rd[8*gi +: 8] = lane_rd_q;
      end
   endgenerate

`ifdef NATIVE_RAM_STATS_EN
   logic        instr_q, instr_d;
   logic [31:0] st_fetch_q, st_fetch_d;
   logic [31:0] st_read_q, st_read_d;
   logic [31:0] st_write_q, st_write_d;
   logic        req_instr;

   assign req_instr = (state_q == S_IDLE) ? mem_instr : instr_q;

   // Count each completed transaction once: a fetch, a data read or a write.
   always_comb begin
      instr_d    = instr_q;
      st_fetch_d = st_fetch_q;
      st_read_d  = st_read_q;
      st_write_d = st_write_q;
      if ((state_q == S_IDLE) && mem_valid) begin
         instr_d = mem_instr;
      end
      if (access) begin
         if (req_instr) begin
            st_fetch_d = st_fetch_q + 32'd1;
         end else if (req_wstrb == 4'd0) begin
            st_read_d = st_read_q + 32'd1;
         end else begin
            st_write_d = st_write_q + 32'd1;
         end
      end
   end

   // Statistics registers; they wrap and are cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q    <= 1'b0;
         st_fetch_q <= 32'd0;
         st_read_q  <= 32'd0;
         st_write_q <= 32'd0;
      end else begin
         instr_q    <= instr_d;
         st_fetch_q <= st_fetch_d;
         st_read_q  <= st_read_d;
         st_write_q <= st_write_d;
      end
   end

   assign stat_rd = io_hit[2] ? st_fetch_q : (io_hit[3] ? st_read_q : st_write_q);
`else
   logic unused_instr;
   assign unused_instr = mem_instr;
   assign stat_rd      = 32'd0;
`endif

   assign mem_ready = ready_q;
   assign mem_rdata = rsel_ram_q ? ram_rd : rdata_q;
   assign io_valid  = io_valid_q;
   assign io_data   = io_data_q;
   assign err       = err_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_native_wait_ram.sv
// tb_native_wait_ram: bench for native_wait_ram.
// It runs two instances, one with zero wait states and one with three.
// Directed and random transactions are compared against a reference model of the
// memory map, the cycle count, the error flag and the statistics counters.
module tb_native_wait_ram;

   localparam logic [31:0] IO_BASE = 32'h1000_0000;
   localparam int          MW      = 256;
`ifdef NATIVE_RAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        valid [2];
   logic        instr [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  wstrb [2];
   logic        ready [2];
   logic [31:0] rdata [2];
   logic        iov   [2];
   logic [7:0]  iod   [2];
   logic        errf  [2];
   logic [31:0] erra  [2];

   native_wait_ram #(.MEM_WORDS(MW), .WAIT_CYCLES(0), .IO_ADDR(IO_BASE)) u_dut0 (
      .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
      .mem_ready(ready[0]), .mem_rdata(rdata[0]), .io_valid(iov[0]), .io_data(iod[0]),
      .err(errf[0]), .err_addr(erra[0]));

   native_wait_ram #(.MEM_WORDS(MW), .WAIT_CYCLES(3), .IO_ADDR(IO_BASE)) u_dut1 (
      .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
      .mem_ready(ready[1]), .mem_rdata(rdata[1]), .io_valid(iov[1]), .io_data(iod[1]),
      .err(errf[1]), .err_addr(erra[1]));

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;
   int rst_edge [2];

   // Reference model state.
   logic [31:0] m_mem   [2][MW];
   bit          m_known [2][MW];
   bit          m_err   [2];
   logic [31:0] m_erra  [2];
   logic [7:0]  m_iod   [2];
   int unsigned m_fetch [2];
   int unsigned m_rd    [2];
   int unsigned m_wr    [2];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %08h expected %08h", tag, $time, got, exp);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic model_reset(input int d);
      m_err[d]   = 1'b0;
      m_erra[d]  = 32'd0;
      m_iod[d]   = 8'd0;
      m_fetch[d] = 0;
      m_rd[d]    = 0;
      m_wr[d]    = 0;
   endtask

   task automatic check_reset_outputs(input int d);
      check32("rst_ready", {31'b0, ready[d]}, 32'd0);
      check32("rst_rdata", rdata[d], 32'd0);
      check32("rst_io_valid", {31'b0, iov[d]}, 32'd0);
      check32("rst_io_data", {24'b0, iod[d]}, 32'd0);
      check32("rst_err", {31'b0, errf[d]}, 32'd0);
      check32("rst_err_addr", erra[d], 32'd0);
   endtask

   // Called at a falling edge; holds reset for cyc rising edges.
   task automatic do_reset(input int d, input int cyc);
      rst[d]   = 1'b1;
      valid[d] = 1'b0;
      wstrb[d] = 4'h0;
      instr[d] = 1'b0;
      repeat (cyc) @(negedge clk);
      check_reset_outputs(d);
      rst[d]      = 1'b0;
      rst_edge[d] = edge_cnt;
      model_reset(d);
   endtask

   // One complete transaction, started and finished on a falling edge.
   task automatic do_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins);
      logic [31:0] al, off, exp_rd, word;
      logic [7:0]  idx;
      bit          is_ram, is_bad, chk_rd, exp_iov;
      int          n, lat, w;
      w       = wait_of(d);
      al      = {a[31:2], 2'b00};
      off     = al - IO_BASE;
      idx     = al[9:2];
      is_ram  = (al < 32'(4 * MW));
      is_bad  = 1'b0;
      exp_rd  = 32'd0;
      exp_iov = 1'b0;
      chk_rd  = (ws == 4'h0);
      n       = edge_cnt;
      if (is_ram) begin
         exp_rd = m_mem[d][idx];
         if (!m_known[d][idx]) chk_rd = 1'b0;
      end else if (al >= IO_BASE && off <= 32'd16) begin
         case (off[4:2])
            3'd0:    exp_iov = (ws != 4'h0);
            3'd1:    exp_rd  = 32'(n + w - rst_edge[d]);
            3'd2:    exp_rd  = STATS ? 32'(m_fetch[d]) : 32'd0;
            3'd3:    exp_rd  = STATS ? 32'(m_rd[d]) : 32'd0;
            default: exp_rd  = STATS ? 32'(m_wr[d]) : 32'd0;
         endcase
      end else begin
         is_bad = 1'b1;
      end

      valid[d] = 1'b1;
      addr[d]  = a;
      wdata[d] = wd;
      wstrb[d] = ws;
      instr[d] = ins;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (ready[d] !== 1'b1 && lat < 40);
      valid[d] = 1'b0;
      wstrb[d] = 4'h0;
      instr[d] = 1'b0;

      // Apply the transaction's effects to the model.
      if (is_ram && ws != 4'h0) begin
         word = m_mem[d][idx];
         for (int b = 0; b < 4; b++) if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
         m_mem[d][idx] = word;
         if (ws == 4'hF) m_known[d][idx] = 1'b1;
      end
      if (exp_iov) m_iod[d] = wd[7:0];
      if (is_bad) begin
         if (!m_err[d]) m_erra[d] = a;
         m_err[d] = 1'b1;
      end
      if (ins) m_fetch[d]++;
      else if (ws == 4'h0) m_rd[d]++;
      else m_wr[d]++;

      check32("latency", 32'(lat), 32'(w + 1));
      if (chk_rd) check32("rdata", rdata[d], exp_rd);
      check32("io_valid", {31'b0, iov[d]}, {31'b0, exp_iov});
      check32("io_data", {24'b0, iod[d]}, {24'b0, m_iod[d]});
      check32("err", {31'b0, errf[d]}, {31'b0, m_err[d]});
      check32("err_addr", erra[d], m_erra[d]);
      $display("txn dut%0d addr=%08h wstrb=%h instr=%0d wdata=%08h rdata=%08h lat=%0d",
               d, a, ws, ins, wd, rdata[d], lat);
      @(negedge clk);
      check32("ready_pulse", {31'b0, ready[d]}, 32'd0);
      check32("io_valid_pulse", {31'b0, iov[d]}, 32'd0);
      if (chk_rd) check32("rdata_hold", rdata[d], exp_rd);
   endtask

   function automatic logic [31:0] pick_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5) begin
         if ($urandom_range(0, 7) == 0) return 32'h3FC | 32'($urandom_range(0, 3));
         return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end
      if (k <= 7) return IO_BASE + 32'($urandom_range(0, 4) * 4);
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0400;
         1:       return IO_BASE + 32'h14;
         2:       return IO_BASE - 32'h4;
         default: return 32'h2000_0000 | 32'($urandom_range(0, 255) * 4);
      endcase
   endfunction

   task automatic random_txns(input int d, input int count);
      logic [31:0] a, wd;
      logic [3:0]  ws;
      logic        ins;
      for (int i = 0; i < count; i++) begin
         a   = pick_addr();
         wd  = $urandom;
         ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         ins = (ws == 4'h0) && ($urandom_range(0, 2) == 0);
         do_txn(d, a, wd, ws, ins);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_ready;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; valid[d] = 1'b0; instr[d] = 1'b0;
         addr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'h0;
         rst_edge[d] = 0;
         model_reset(d);
         for (int j = 0; j < MW; j++) begin
            m_mem[d][j]   = 32'd0;
            m_known[d][j] = 1'b0;
         end
      end
      @(negedge clk);
      do_reset(0, 2);
      do_reset(1, 1);

      // Give every RAM word the bench touches a defined value.
      for (int d = 0; d < 2; d++) begin
         for (int j = 0; j < 16; j++) do_txn(d, 32'(j * 4), $urandom, 4'hF, 1'b0);
         do_txn(d, 32'h3FC, 32'h0, 4'hF, 1'b0);
      end

      // Zero-wait instance: fetch, console, cycle counter, unmapped accesses.
      do_txn(0, 32'h0, 32'h3fc00093, 4'hF, 1'b0);
      do_txn(0, 32'h0, 32'h0, 4'h0, 1'b1);
      check32("fetch_word", rdata[0], 32'h3fc00093);
      do_txn(0, IO_BASE, 32'h0000_0041, 4'h1, 1'b0);
      check32("console_byte", {24'b0, iod[0]}, 32'h41);
      do_txn(0, IO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
      repeat (7) @(negedge clk);
      do_txn(0, IO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);
      do_txn(0, 32'h2000_0000, 32'h0, 4'h0, 1'b0);
      do_txn(0, 32'h3000_0000, 32'h0, 4'h0, 1'b0);
      check32("first_err_addr", erra[0], 32'h2000_0000);
      random_txns(0, 40);

      // Three-wait instance: partial write at the top RAM word.
      do_txn(1, 32'h3FC, 32'hAABBCCDD, 4'b0101, 1'b0);
      do_txn(1, 32'h3FC, 32'h0, 4'h0, 1'b0);
      check32("partial_readback", rdata[1], 32'h00BB00DD);

      // Statistics: 3 fetches, 2 reads, 1 write after a fresh reset.
      do_reset(1, 1);
      for (int j = 0; j < 3; j++) do_txn(1, 32'(j * 4), 32'h0, 4'h0, 1'b1);
      do_txn(1, 32'h10, 32'h0, 4'h0, 1'b0);
      do_txn(1, 32'h14, 32'h0, 4'h0, 1'b0);
      do_txn(1, 32'h18, 32'h5555_AAAA, 4'hF, 1'b0);
      do_txn(1, IO_BASE + 32'hC, 32'h0, 4'h0, 1'b0);
      check32("stat_reads", rdata[1], STATS ? 32'd2 : 32'd0);
      do_txn(1, IO_BASE + 32'h8, 32'h0, 4'h0, 1'b0);
      check32("stat_fetches", rdata[1], STATS ? 32'd3 : 32'd0);
      do_txn(1, IO_BASE + 32'h10, 32'h0, 4'h0, 1'b0);
      check32("stat_writes", rdata[1], STATS ? 32'd1 : 32'd0);
      check32("stat_no_err", {31'b0, errf[1]}, 32'd0);

      // Request withdrawn during wait states: no access, error raised.
      valid[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'hF;
      @(negedge clk);
      valid[1] = 1'b0; wstrb[1] = 4'h0;
      saw_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ready[1] === 1'b1) saw_ready = 1'b1;
      end
      if (!m_err[1]) m_erra[1] = 32'h24;
      m_err[1] = 1'b1;
      check32("drop_no_ready", {31'b0, saw_ready}, 32'd0);
      check32("drop_err", {31'b0, errf[1]}, 32'd1);
      check32("drop_err_addr", erra[1], m_erra[1]);
      do_txn(1, 32'h24, 32'h0, 4'h0, 1'b0);

      random_txns(1, 40);

      // Reset two cycles into a waited write: abandoned, RAM untouched.
      do_txn(1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
      valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'hF;
      saw_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ready[1] === 1'b1) saw_ready = 1'b1;
      end
      rst[1] = 1'b1;
      @(negedge clk);
      if (ready[1] === 1'b1) saw_ready = 1'b1;
      check_reset_outputs(1);
      valid[1] = 1'b0; wstrb[1] = 4'h0;
      @(negedge clk);
      if (ready[1] === 1'b1) saw_ready = 1'b1;
      rst[1]      = 1'b0;
      rst_edge[1] = edge_cnt;
      model_reset(1);
      check32("midwait_no_ready", {31'b0, saw_ready}, 32'd0);
      do_txn(1, 32'h20, 32'h0, 4'h0, 1'b0);
      check32("midwait_word_kept", rdata[1], 32'h1234_5678);
      do_txn(1, IO_BASE + 32'h4, 32'h0, 4'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
